// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the single-issue RV32 core.
// Owns the PC and drives it to the combinational instruction memory. Each edge it
// latches {pc, pc+4, inst, valid} into the IF/ID register. The register is held
// when decode stalls. It is loaded with a bubble on a redirect or while halted.
// The halt opcode stops fetch after decode has seen the halt word once.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
// When the macro is undefined, fetch_cnt_o and stall_cnt_o read as zero.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INST    = 32'h0000_0033,
    parameter logic [6:0]  HALT_OPCODE = 7'h7F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_inst_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_inst_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] if_id_pc_reg, if_id_pc_next;
    logic [31:0] if_id_pc4_reg, if_id_pc4_next;
    logic [31:0] if_id_inst_reg, if_id_inst_next;
    logic        if_id_valid_reg, if_id_valid_next;

    logic [31:0] pc_plus4;
    logic        is_halt;
    logic        fetch_load;

    // PC+4 wraps naturally modulo 2^32.
    assign pc_plus4 = pc_reg + 32'd4;
    assign is_halt  = (imem_inst_i[6:0] == HALT_OPCODE);

    // A real instruction enters IF/ID only in RUN when there is no redirect and no stall.
    assign fetch_load = !redirect_i && !stall_i && (state_reg == ST_RUN);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: a redirect always resumes, a stall freezes, and a halt word in RUN stops fetch.
    always_comb begin
        state_next = state_reg;
        if (redirect_i) begin
            state_next = ST_RUN;
        end else if (stall_i) begin
            state_next = state_reg;
        end else if (state_reg == ST_RUN && is_halt) begin
            state_next = ST_HALTED;
        end
    end

    // FSM outputs.
    always_comb begin
        halted_o = (state_reg == ST_HALTED);
    end

    // Next PC and IF/ID contents, in the same priority order as the state transitions.
    always_comb begin
        pc_next          = pc_reg;
        if_id_pc_next    = if_id_pc_reg;
        if_id_pc4_next   = if_id_pc4_reg;
        if_id_inst_next  = if_id_inst_reg;
        if_id_valid_next = if_id_valid_reg;
        if (redirect_i) begin
            // Squash: the bubble keeps the old pc/pc4. Misaligned targets are aligned down.
            pc_next          = redirect_pc_i & ~32'h3;
            if_id_inst_next  = NOP_INST;
            if_id_valid_next = 1'b0;
        end else if (stall_i) begin
            pc_next = pc_reg;
        end else if (state_reg == ST_RUN) begin
            if_id_pc_next    = pc_reg;
            if_id_pc4_next   = pc_plus4;
            if_id_inst_next  = imem_inst_i;
            if_id_valid_next = 1'b1;
            // The halt word is delivered once, and the PC then parks on it.
            pc_next          = is_halt ? pc_reg : pc_plus4;
        end else begin
            if_id_inst_next  = NOP_INST;
            if_id_valid_next = 1'b0;
        end
    end

    // PC and IF/ID pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            if_id_pc_reg    <= 32'h0;
            if_id_pc4_reg   <= 32'h0;
            if_id_inst_reg  <= NOP_INST;
            if_id_valid_reg <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            if_id_pc_reg    <= if_id_pc_next;
            if_id_pc4_reg   <= if_id_pc4_next;
            if_id_inst_reg  <= if_id_inst_next;
            if_id_valid_reg <= if_id_valid_next;
        end
    end

    assign imem_pc_o     = pc_reg;
    assign if_id_pc_o    = if_id_pc_reg;
    assign if_id_pc4_o   = if_id_pc4_reg;
    assign if_id_inst_o  = if_id_inst_reg;
    assign if_id_valid_o = if_id_valid_reg;

`ifdef FETCH_PERF_CNT_EN
    // Index 0 counts delivered instructions. Index 1 counts stall cycles seen in RUN.
    logic [1:0]  cnt_inc;
    logic [31:0] cnt_val [2];

    assign cnt_inc[0] = fetch_load;
    assign cnt_inc[1] = stall_i && !redirect_i && (state_reg == ST_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [31:0] cnt_reg;

            // Saturating event counter, cleared only by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= 32'h0;
                end else if (cnt_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign fetch_cnt_o = cnt_val[0];
    assign stall_cnt_o = cnt_val[1];
`else
    assign fetch_cnt_o = 32'h0;
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage.
// Instruction memory is a combinational array of addi words. Word 0x24 holds the
// halt opcode. Addresses at or above 0x100 return a plain addi word.
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_pc_o;
    logic [31:0] imem_inst_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;
    logic        halted_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;

    logic [31:0] mem [0:63];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] exp_cnt;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_pc_o     (imem_pc_o),
        .imem_inst_i   (imem_inst_i),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_inst_o  (if_id_inst_o),
        .if_id_valid_o (if_id_valid_o),
        .halted_o      (halted_o),
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    assign imem_inst_i = (imem_pc_o[31:8] == 24'h0) ? mem[imem_pc_o[7:2]] : 32'h0000_0013;

    // One clock edge, then settle #1 and log the transaction.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d: stall=%0b redir=%0b pc=%h ifid_pc=%h ifid_inst=%h v=%0b halted=%0b",
                 cyc, stall_i, redirect_i, imem_pc_o, if_id_pc_o, if_id_inst_o,
                 if_id_valid_o, halted_o);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        #12;
        total++; if (imem_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", imem_pc_o, 32'h0); end
        total++; if (if_id_inst_o !== 32'h33) begin bad++; $display("FAIL reset_inst got=%h want=%h", if_id_inst_o, 32'h33); end
        total++; if (if_id_valid_o !== 1'b0 || halted_o !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", if_id_valid_o, halted_o); end
        total++; if (fetch_cnt_o !== 32'h0 || stall_cnt_o !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h want=0/0", fetch_cnt_o, stall_cnt_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        tick(); tick(); tick();
        total++; if (imem_pc_o !== 32'hC) begin bad++; $display("FAIL t1_pc got=%h want=%h", imem_pc_o, 32'hC); end
        total++; if (if_id_pc_o !== 32'h8 || if_id_pc4_o !== 32'hC) begin bad++; $display("FAIL t1_ifid_pc got=%h/%h want=8/c", if_id_pc_o, if_id_pc4_o); end
        total++; if (if_id_inst_o !== 32'h0020_8093 || if_id_valid_o !== 1'b1) begin bad++; $display("FAIL t1_inst got=%h v=%b want=00208093 v=1", if_id_inst_o, if_id_valid_o); end
        exp_cnt = PERF ? 32'd3 : 32'd0;
        total++; if (fetch_cnt_o !== exp_cnt) begin bad++; $display("FAIL t1_fetch_cnt got=%0d want=%0d", fetch_cnt_o, exp_cnt); end
    endtask

    task automatic test_stall();
        tick();
        stall_i = 1'b1;
        tick(); tick();
        total++; if (imem_pc_o !== 32'h10) begin bad++; $display("FAIL t2_hold_pc got=%h want=%h", imem_pc_o, 32'h10); end
        total++; if (if_id_pc_o !== 32'hC || if_id_inst_o !== 32'h0030_8093 || if_id_valid_o !== 1'b1) begin bad++; $display("FAIL t2_hold_ifid got=%h/%h want=c/00308093", if_id_pc_o, if_id_inst_o); end
        exp_cnt = PERF ? 32'd2 : 32'd0;
        total++; if (stall_cnt_o !== exp_cnt) begin bad++; $display("FAIL t2_stall_cnt got=%0d want=%0d", stall_cnt_o, exp_cnt); end
        stall_i = 1'b0;
        tick();
        total++; if (if_id_pc_o !== 32'h10 || if_id_inst_o !== 32'h0040_8093 || imem_pc_o !== 32'h14) begin bad++; $display("FAIL t2_release got=%h/%h pc=%h want=10/00408093 pc=14", if_id_pc_o, if_id_inst_o, imem_pc_o); end
        exp_cnt = PERF ? 32'd5 : 32'd0;
        total++; if (fetch_cnt_o !== exp_cnt) begin bad++; $display("FAIL t2_fetch_cnt got=%0d want=%0d", fetch_cnt_o, exp_cnt); end
    endtask

    task automatic test_redirect();
        redirect_i = 1'b1; redirect_pc_i = 32'h2E; stall_i = 1'b1;
        tick();
        redirect_i = 1'b0; stall_i = 1'b0;
        total++; if (imem_pc_o !== 32'h2C) begin bad++; $display("FAIL t3_pc got=%h want=%h", imem_pc_o, 32'h2C); end
        total++; if (if_id_inst_o !== 32'h33 || if_id_valid_o !== 1'b0 || if_id_pc_o !== 32'h10) begin bad++; $display("FAIL t3_bubble got=%h v=%b pc=%h want=33 v=0 pc=10", if_id_inst_o, if_id_valid_o, if_id_pc_o); end
        exp_cnt = PERF ? 32'd2 : 32'd0;
        total++; if (stall_cnt_o !== exp_cnt) begin bad++; $display("FAIL t3_stall_cnt got=%0d want=%0d", stall_cnt_o, exp_cnt); end
        tick();
        total++; if (if_id_pc_o !== 32'h2C || if_id_pc4_o !== 32'h30 || if_id_valid_o !== 1'b1 || imem_pc_o !== 32'h30) begin bad++; $display("FAIL t3_after got=%h/%h v=%b pc=%h want=2c/30 v=1 pc=30", if_id_pc_o, if_id_pc4_o, if_id_valid_o, imem_pc_o); end
    endtask

    task automatic test_halt();
        redirect_i = 1'b1; redirect_pc_i = 32'h20;
        tick();
        redirect_i = 1'b0;
        tick();
        tick();
        total++; if (if_id_inst_o !== 32'h7F || if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h24) begin bad++; $display("FAIL t4_halt_word got=%h v=%b pc=%h want=7f v=1 pc=24", if_id_inst_o, if_id_valid_o, if_id_pc_o); end
        total++; if (halted_o !== 1'b1 || imem_pc_o !== 32'h24) begin bad++; $display("FAIL t4_halted got=%b pc=%h want=1 pc=24", halted_o, imem_pc_o); end
        tick();
        total++; if (if_id_inst_o !== 32'h33 || if_id_valid_o !== 1'b0 || imem_pc_o !== 32'h24 || halted_o !== 1'b1) begin bad++; $display("FAIL t4_bubble got=%h v=%b pc=%h h=%b want=33 v=0 pc=24 h=1", if_id_inst_o, if_id_valid_o, imem_pc_o, halted_o); end
        stall_i = 1'b1;
        tick();
        stall_i = 1'b0;
        exp_cnt = PERF ? 32'd2 : 32'd0;
        total++; if (stall_cnt_o !== exp_cnt || halted_o !== 1'b1) begin bad++; $display("FAIL t4_halt_stall got=%0d h=%b want=%0d h=1", stall_cnt_o, halted_o, exp_cnt); end
    endtask

    task automatic test_resume();
        redirect_i = 1'b1; redirect_pc_i = 32'h8;
        tick();
        redirect_i = 1'b0;
        total++; if (halted_o !== 1'b0 || imem_pc_o !== 32'h8 || if_id_valid_o !== 1'b0) begin bad++; $display("FAIL t5_resume got=h%b pc=%h v=%b want=h0 pc=8 v=0", halted_o, imem_pc_o, if_id_valid_o); end
        tick();
        total++; if (if_id_pc_o !== 32'h8 || if_id_inst_o !== 32'h0020_8093 || imem_pc_o !== 32'hC) begin bad++; $display("FAIL t5_fetch got=%h/%h pc=%h want=8/00208093 pc=c", if_id_pc_o, if_id_inst_o, imem_pc_o); end
    endtask

    task automatic test_wrap_and_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        total++; if (imem_pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL t6_align got=%h want=fffffffc", imem_pc_o); end
        tick();
        total++; if (imem_pc_o !== 32'h0 || if_id_pc_o !== 32'hFFFF_FFFC || if_id_pc4_o !== 32'h0) begin bad++; $display("FAIL t6_wrap got=pc%h ifid %h/%h want=0 fffffffc/0", imem_pc_o, if_id_pc_o, if_id_pc4_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h24;
        tick();
        redirect_i = 1'b0;
        tick();
        total++; if (halted_o !== 1'b1) begin bad++; $display("FAIL t6_pre_halt got=%b want=1", halted_o); end
        rst_n = 1'b0;
        #1;
        total++; if (imem_pc_o !== 32'h0 || if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin bad++; $display("FAIL t6_async_pc got=%h %h/%h want=0 0/0", imem_pc_o, if_id_pc_o, if_id_pc4_o); end
        total++; if (if_id_inst_o !== 32'h33 || if_id_valid_o !== 1'b0 || halted_o !== 1'b0) begin bad++; $display("FAIL t6_async_flags got=%h v=%b h=%b want=33 v=0 h=0", if_id_inst_o, if_id_valid_o, halted_o); end
        total++; if (fetch_cnt_o !== 32'h0 || stall_cnt_o !== 32'h0) begin bad++; $display("FAIL t6_async_cnt got=%h/%h want=0/0", fetch_cnt_o, stall_cnt_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        total++; if (if_id_pc_o !== 32'h0 || if_id_inst_o !== 32'h0000_8093 || if_id_valid_o !== 1'b1 || imem_pc_o !== 32'h4) begin bad++; $display("FAIL t6_restart got=%h/%h v=%b pc=%h want=0/00008093 v=1 pc=4", if_id_pc_o, if_id_inst_o, if_id_valid_o, imem_pc_o); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {i[11:0], 5'd1, 3'b000, 5'd1, 7'h13};
        end
        mem[9] = 32'h0000_007F;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_resume();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
